alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Upstream issue/sequencing stage for the 8-bit combinational ALU.
- Accepts ALU commands over a valid/ready handshake and registers the operands and opcode that drive the ALU.
- Captures the ALU result one cycle later and presents it downstream with a valid/ready handshake, plus status flags and a tag.
- Provides accumulator chaining (operand A taken from the last good result), divide-by-zero trapping, and a response counter.

Parameters:
- TAG_W, 4, width of the command/response tag.
- CNT_W, 16, width of the completed-response counter.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  stage can accept command
- cmd_op  in  4  ALU opcode (0000 ADD … 1111 EQ)
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_use_acc  in  1  1 = use accumulator as operand A, ignore cmd_a
- cmd_tag  in  TAG_W  opaque tag, returned with response
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_op  out  4  registered opcode to ALU
- alu_result  in  8  ALU combinational result
- alu_carry  in  1  ALU carry flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  downstream accepts response
- rsp_result  out  8  captured result
- rsp_carry  out  1  carry; alu_carry for op 0000, else 0
- rsp_zero  out  1  rsp_result == 0
- rsp_err  out  1  divide-by-zero trap
- rsp_tag  out  TAG_W  tag of command
- acc_value  out  8  current accumulator
- rsp_count  out  CNT_W  completed response handshakes

Behaviour:
- Reset values: FSM IDLE. The following all reset to 0: cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, rsp_tag, acc_value, rsp_count.
  - cmd_ready goes to 1 in the first cycle after rst_n deasserts.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. On cmd_valid the stage loads operand regs (alu_a = use_acc ? acc : cmd_a; alu_b = cmd_b; alu_op = cmd_op), latches tag and div-zero flag, then goes to EXEC.
  - EXEC: cmd_ready=0, alu_* stable for the whole cycle. At the next edge it captures the response registers, sets rsp_valid=1, goes to RESP.
  - RESP: rsp_valid=1; response registers hold stable until rsp_ready.
    - cmd_ready = rsp_ready (combinational).
    - rsp_ready with cmd_valid: response retires and the new command loads the same edge → EXEC.
    - rsp_ready without cmd_valid: → IDLE.
- Latency: command accepted at edge k, rsp_valid=1 after edge k+1. Peak throughput is one op per 2 cycles.
- Capture rules:
  - rsp_zero is computed from the final rsp_result.
  - rsp_carry = (op==0000) ? alu_carry : 0.
- Divide-by-zero: when op==0011 and the selected operand B==0, the response is rsp_result=8'hFF, rsp_err=1, rsp_carry=0, rsp_zero=0. alu_result is ignored (it may be X).
- Accumulator:
  - Updated with rsp_result at the capture edge only when rsp_err=0.
  - Erroneous ops leave acc unchanged.
  - use_acc on a command accepted in RESP sees the value captured at the previous capture edge.
- rsp_count increments on every rsp_valid&&rsp_ready edge, errors included. It wraps 2^CNT_W-1 → 0 silently.
- alu_a/alu_b/alu_op hold their last values outside EXEC, so the ALU sees no spurious toggles.
- cmd_* inputs are ignored when cmd_ready=0. The upstream must hold cmd_* stable while cmd_valid=1 and cmd_ready=0.
- Reset mid-operation (any state): asynchronous return to the reset values. The in-flight command and any pending response are discarded without handshake, and the accumulator clears.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode constants (OP_ADD…OP_EQ, OP_DIV=4'b0011).
  - FSM state encoding.
  - Constant DIVZ_RESULT=8'hFF.
- Single module; no sub-module required. The response counter may be a trivial inline always block.

Test Plan:
- ADD a=8'h0F, b=8'h01, rsp_ready=1 → rsp_valid one cycle after accept; result 8'h10, carry = ALU carry, zero=0, err=0, tag echoed, rsp_count=1.
- DIV a=8'h20, b=8'h00 → result 8'hFF, err=1, carry=0; acc_value unchanged from its prior 8'h10.
- Chain: SUB a=8'h05, b=8'h05 (result 0, zero=1), then ADD use_acc=1, b=8'h07 → alu_a=8'h00, result 8'h07, acc_value=8'h07.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 → cmd_ready=0, rsp_* stable. On rsp_ready=1 the next command is accepted the same edge with no bubble beyond EXEC.
- Reset: assert rst_n=0 mid-EXEC → all outputs 0 immediately, no response emitted; after release, IDLE with cmd_ready=1.
- Counter wrap (CNT_W=2): 5 back-to-back handshakes → rsp_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode map, FSM encoding and
// the fixed response used when a divide by zero is trapped.
package alu_pkg;

  // 4-bit ALU opcode map
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_INC = 4'b1100;
  localparam logic [3:0] OP_DEC = 4'b1101;
  localparam logic [3:0] OP_LT  = 4'b1110;
  localparam logic [3:0] OP_EQ  = 4'b1111;

  // Result presented when a divide by zero is trapped
  localparam logic [7:0] DIVZ_RESULT = 8'hFF;

  // Issue-stage sequencing states
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } state_e;

  // True when a command would divide by zero
  function automatic logic is_div_zero(input logic [3:0] op, input logic [7:0] b);
    return (op == OP_DIV) && (b == 8'h00);
  endfunction

endpackage

// File: rtl/alu_issue_stage.sv
// Issue/sequencing stage in front of the 8-bit combinational ALU. Registers
// operands for one EXEC cycle, captures the ALU result into a held response,
// chains results through an accumulator and traps divide by zero.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_use_acc,
  input  logic [TAG_W-1:0] cmd_tag,
  // ALU interface
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_op,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  // status
  output logic [7:0]       acc_value,
  output logic [CNT_W-1:0] rsp_count
);

  state_e           state_q;
  logic             ready_en_q;  // holds cmd_ready low for the first cycle out of reset
  logic [TAG_W-1:0] tag_q;
  logic             divz_q;

  logic       cmd_fire;
  logic       rsp_fire;
  logic [7:0] op_a_sel;
  logic [7:0] cap_result;
  logic       cap_carry;

  // Handshake qualifiers and operand-A selection
  always_comb begin
    cmd_fire = cmd_valid && cmd_ready;
    rsp_fire = rsp_valid && rsp_ready;
    op_a_sel = cmd_use_acc ? acc_value : cmd_a;
  end

  // Command acceptance: open in IDLE, follows rsp_ready in RESP so a new
  // command can load on the same edge the old response retires
  always_comb begin
    cmd_ready = 1'b0;
    unique case (state_q)
      StIdle:  cmd_ready = ready_en_q;
      StExec:  cmd_ready = 1'b0;
      StResp:  cmd_ready = rsp_ready;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Response values formed from the ALU outputs during EXEC
  always_comb begin
    cap_result = divz_q ? DIVZ_RESULT : alu_result;
    cap_carry  = (!divz_q && (alu_op == OP_ADD)) ? alu_carry : 1'b0;
  end

  // Sequencing FSM and response-valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ready_en_q <= 1'b0;
      rsp_valid  <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (cmd_fire) begin
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= cmd_valid ? StExec : StIdle;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  // Operand registers: only change on an accepted command, so the ALU
  // inputs stay quiet outside EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= 8'h00;
      alu_b  <= 8'h00;
      alu_op <= 4'h0;
      tag_q  <= '0;
      divz_q <= 1'b0;
    end else if (cmd_fire) begin
      alu_a  <= op_a_sel;
      alu_b  <= cmd_b;
      alu_op <= cmd_op;
      tag_q  <= cmd_tag;
      divz_q <= is_div_zero(cmd_op, cmd_b);
    end
  end

  // Response capture at the end of EXEC; held until the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= 8'h00;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
    end else if (state_q == StExec) begin
      rsp_result <= cap_result;
      rsp_carry  <= cap_carry;
      rsp_zero   <= (cap_result == 8'h00);
      rsp_err    <= divz_q;
      rsp_tag    <= tag_q;
    end
  end

  // Accumulator follows the last non-trapped result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_value <= 8'h00;
    end else if ((state_q == StExec) && !divz_q) begin
      acc_value <= cap_result;
    end
  end

  // Completed-response counter, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_count <= '0;
    end else if (rsp_fire) begin
      rsp_count <= rsp_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage. A tiny ALU model drives
// alu_result/alu_carry from the registered operands; all expected values are
// hand-computed constants. CNT_W is 2 so the counter wrap is exercised.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic             cmd_use_acc;
  logic [TAG_W-1:0] cmd_tag;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_op;
  logic [7:0]       alu_result;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;
  logic [7:0]       acc_value;
  logic [CNT_W-1:0] rsp_count;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(
    .TAG_W(TAG_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .rsp_tag    (rsp_tag),
    .acc_value  (acc_value),
    .rsp_count  (rsp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal ALU: SUB always raises carry (must be masked), DIV by zero
  // returns junk (must be replaced by the trap value)
  always_comb begin
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    case (alu_op)
      OP_ADD: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB: begin
        alu_result = alu_a - alu_b;
        alu_carry  = 1'b1;
      end
      OP_DIV: alu_result = (alu_b == 8'h00) ? 8'hAA : alu_a / alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for acceptance, then drop cmd_valid.
  // Returns just after the accept edge, i.e. in EXEC.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic use_acc, input logic [TAG_W-1:0] tag);
    int n;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
    cmd_tag     = tag;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("accept_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 4'h0;
    cmd_a       = 8'h00;
    cmd_b       = 8'h00;
    cmd_use_acc = 1'b0;
    cmd_tag     = '0;
    rsp_ready   = 1'b1;

    // Reset state
    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_acc", 32'(acc_value), 32'd0);
    check("rst_count", 32'(rsp_count), 32'd0);
    #19 rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // ADD 0F+01
    send(OP_ADD, 8'h0F, 8'h01, 1'b0, 4'h3);
    check("add_alu_a", 32'(alu_a), 32'h0F);
    check("add_alu_b", 32'(alu_b), 32'h01);
    check("add_exec_ready", 32'(cmd_ready), 32'd0);
    check("add_exec_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("add_valid", 32'(rsp_valid), 32'd1);
    check("add_result", 32'(rsp_result), 32'h10);
    check("add_carry", 32'(rsp_carry), 32'd0);
    check("add_zero", 32'(rsp_zero), 32'd0);
    check("add_err", 32'(rsp_err), 32'd0);
    check("add_tag", 32'(rsp_tag), 32'h3);
    check("add_acc", 32'(acc_value), 32'h10);
    tick();
    check("add_count", 32'(rsp_count), 32'd1);
    check("add_retired", 32'(rsp_valid), 32'd0);

    // DIV by zero
    send(OP_DIV, 8'h20, 8'h00, 1'b0, 4'h5);
    tick();
    check("div_result", 32'(rsp_result), 32'hFF);
    check("div_err", 32'(rsp_err), 32'd1);
    check("div_carry", 32'(rsp_carry), 32'd0);
    check("div_zero", 32'(rsp_zero), 32'd0);
    check("div_tag", 32'(rsp_tag), 32'h5);
    check("div_acc", 32'(acc_value), 32'h10);
    tick();
    check("div_count", 32'(rsp_count), 32'd2);

    // SUB 05-05 -> zero, carry masked
    send(OP_SUB, 8'h05, 8'h05, 1'b0, 4'h6);
    tick();
    check("sub_result", 32'(rsp_result), 32'h00);
    check("sub_zero", 32'(rsp_zero), 32'd1);
    check("sub_carry", 32'(rsp_carry), 32'd0);
    check("sub_acc", 32'(acc_value), 32'h00);
    tick();
    check("sub_count", 32'(rsp_count), 32'd3);

    // Chained ADD from accumulator; cmd_a must be ignored
    send(OP_ADD, 8'h99, 8'h07, 1'b1, 4'h7);
    check("chain_alu_a", 32'(alu_a), 32'h00);
    tick();
    check("chain_result", 32'(rsp_result), 32'h07);
    check("chain_acc", 32'(acc_value), 32'h07);
    tick();
    check("wrap_count", 32'(rsp_count), 32'd0);

    // ADD with carry out
    send(OP_ADD, 8'hF0, 8'h20, 1'b0, 4'h8);
    tick();
    check("addc_result", 32'(rsp_result), 32'h10);
    check("addc_carry", 32'(rsp_carry), 32'd1);
    tick();
    check("addc_count", 32'(rsp_count), 32'd1);

    // Backpressure with a chained command waiting
    rsp_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02, 1'b0, 4'h9);
    tick();
    check("bp_result0", 32'(rsp_result), 32'h03);
    cmd_valid   = 1'b1;
    cmd_op      = OP_SUB;
    cmd_a       = 8'h55;
    cmd_b       = 8'h01;
    cmd_use_acc = 1'b1;
    cmd_tag     = 4'hA;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 32'(cmd_ready), 32'd0);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold", {rsp_result, 4'(rsp_tag), 4'(alu_op)}, {8'h03, 4'h9, 4'h0});
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_ready_follow", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("bp_reload_valid", 32'(rsp_valid), 32'd0);
    check("bp_reload_a", 32'(alu_a), 32'h03);
    check("bp_reload_op", 32'(alu_op), 32'(OP_SUB));
    check("bp_count", 32'(rsp_count), 32'd2);
    tick();
    check("bp2_valid", 32'(rsp_valid), 32'd1);
    check("bp2_result", 32'(rsp_result), 32'h02);
    check("bp2_tag", 32'(rsp_tag), 32'hA);
    check("bp2_acc", 32'(acc_value), 32'h02);
    tick();
    check("bp2_count", 32'(rsp_count), 32'd3);

    // Reset in the middle of EXEC
    send(OP_ADD, 8'h10, 8'h10, 1'b0, 4'hB);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_acc", 32'(acc_value), 32'd0);
    check("mid_rst_count", 32'(rsp_count), 32'd0);
    check("mid_rst_rsp", {rsp_result, 4'(rsp_tag)}, 32'd0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    check("post_mid_valid", 32'(rsp_valid), 32'd0);
    check("post_mid_ready", 32'(cmd_ready), 32'd1);

    // Normal operation resumes
    send(OP_ADD, 8'h01, 8'h01, 1'b0, 4'hC);
    tick();
    check("resume_result", 32'(rsp_result), 32'h02);
    check("resume_acc", 32'(acc_value), 32'h02);
    tick();
    check("resume_count", 32'(rsp_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
